ex_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the execute stage.
- Generates the ForwardA/ForwardB selects that steer the EX-stage 3:1 operand muxes.
- Detects load-use hazards and stalls PC and IF/ID while injecting bubbles into ID/EX.
- Sequences the flush of the younger stages when a branch resolves taken from EX/MEM.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/fwd_sel.sv | 29 ++
 rtl/ex_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline control definitions: forwarding select codes, hazard FSM
// state encoding and the hard-wired zero register index.
package pipeline_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

endpackage : pipeline_pkg

// File: rtl/fwd_sel.sv
// Operand forwarding select for one EX-stage source register.
// The younger producer in EX/MEM takes priority over MEM/WB.
module fwd_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] src,
  input  logic       ex_mem_RegWrite,
  input  logic [4:0] ex_mem_reg_dest,
  input  logic       mem_wb_RegWrite,
  input  logic [4:0] mem_wb_reg_dest,
  output logic [1:0] sel
);

  logic ex_mem_hit;
  logic mem_wb_hit;

  assign ex_mem_hit = ex_mem_RegWrite && (ex_mem_reg_dest != REG_ZERO) &&
                      (ex_mem_reg_dest == src);
  assign mem_wb_hit = mem_wb_RegWrite && (mem_wb_reg_dest != REG_ZERO) &&
                      (mem_wb_reg_dest == src);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel = FWD_REG;
    if (ex_mem_hit)      sel = FWD_EXMEM;
    else if (mem_wb_hit) sel = FWD_MEMWB;
  end

endmodule : fwd_sel

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stall
// sequencing, taken-branch flushes and saturating debug event counters.
module ex_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic [4:0]       id_ex_rs,
  input  logic [4:0]       id_ex_rt,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_reg_dest,
  input  logic             ex_mem_RegWrite,
  input  logic [4:0]       ex_mem_reg_dest,
  input  logic             mem_wb_RegWrite,
  input  logic [4:0]       mem_wb_reg_dest,
  input  logic             ex_mem_Branch,
  input  logic             ex_mem_zero,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             pc_src,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0]       STALL_EXTRA = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  hz_state_e  state, state_nxt;
  logic [2:0] rem, rem_nxt;
  logic       hz, bt;
  logic       stall_inc, flush_inc;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  fwd_sel u_fwd_a (
    .src             (id_ex_rs),
    .ex_mem_RegWrite (ex_mem_RegWrite),
    .ex_mem_reg_dest (ex_mem_reg_dest),
    .mem_wb_RegWrite (mem_wb_RegWrite),
    .mem_wb_reg_dest (mem_wb_reg_dest),
    .sel             (fwd_a_raw)
  );

  fwd_sel u_fwd_b (
    .src             (id_ex_rt),
    .ex_mem_RegWrite (ex_mem_RegWrite),
    .ex_mem_reg_dest (ex_mem_reg_dest),
    .mem_wb_RegWrite (mem_wb_RegWrite),
    .mem_wb_reg_dest (mem_wb_reg_dest),
    .sel             (fwd_b_raw)
  );

  assign hz = id_ex_MemRead && (id_ex_reg_dest != REG_ZERO) &&
              ((id_ex_reg_dest == if_id_rs) || (id_ex_reg_dest == if_id_rt));
  assign bt = ex_mem_Branch && ex_mem_zero;

  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    ForwardA     = fwd_a_raw;
    ForwardB     = fwd_b_raw;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pc_src       = 1'b0;

    if (reset) begin
      // Hold the whole pipeline quiescent while reset is asserted.
      ForwardA     = FWD_REG;
      ForwardB     = FWD_REG;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (bt) begin
      // A taken branch overrides both a fresh hazard and a stall in progress.
      pc_src       = 1'b1;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_inc    = 1'b1;
      state_nxt    = ST_RUN;
      rem_nxt      = 3'd0;
    end else if (state == ST_STALL || hz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
      if (state == ST_STALL) begin
        rem_nxt = rem - 3'd1;
        if (rem == 3'd1) state_nxt = ST_RUN;
      end else if (LOAD_STALL_CYCLES > 1) begin
        state_nxt = ST_STALL;
        rem_nxt   = STALL_EXTRA;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      rem         <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      if (stall_inc && stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
      if (flush_inc && flush_count != CNT_MAX) flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule : ex_hazard_ctrl

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: two instances (1-bubble/16-bit
// counters and 3-bubble/4-bit counters) share one stimulus stream.
module tb_ex_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic [4:0] if_rs, if_rt, ex_rs, ex_rt;
    logic       memrd;
    logic [4:0] ld_dest;
    logic       exw;
    logic [4:0] exd;
    logic       mww;
    logic [4:0] mwd;
    logic       br, zero;
  } in_t;

  typedef struct {
    logic [1:0] fa, fb;
    logic       pcw, ifw, bub, fif, fid, fex, psrc;
  } out_t;

  typedef struct {
    in_t        in;
    logic [1:0] fa, fb;
  } fwd_vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, id_ex_reg_dest;
  logic [4:0] ex_mem_reg_dest, mem_wb_reg_dest;
  logic       id_ex_MemRead, ex_mem_RegWrite, mem_wb_RegWrite, ex_mem_Branch, ex_mem_zero;

  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic        pcw [2], ifw [2], bub [2], fif [2], fid [2], fex [2], psrc [2];
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;

  ex_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_l1 (
    .clock(clock), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_reg_dest(id_ex_reg_dest),
    .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_reg_dest(ex_mem_reg_dest),
    .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_reg_dest(mem_wb_reg_dest),
    .ex_mem_Branch(ex_mem_Branch), .ex_mem_zero(ex_mem_zero),
    .ForwardA(fa[0]), .ForwardB(fb[0]), .pc_write(pcw[0]), .if_id_write(ifw[0]),
    .id_ex_bubble(bub[0]), .flush_if_id(fif[0]), .flush_id_ex(fid[0]),
    .flush_ex_mem(fex[0]), .pc_src(psrc[0]), .stall_count(sc_a), .flush_count(fc_a)
  );

  ex_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u_l3 (
    .clock(clock), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_reg_dest(id_ex_reg_dest),
    .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_reg_dest(ex_mem_reg_dest),
    .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_reg_dest(mem_wb_reg_dest),
    .ex_mem_Branch(ex_mem_Branch), .ex_mem_zero(ex_mem_zero),
    .ForwardA(fa[1]), .ForwardB(fb[1]), .pc_write(pcw[1]), .if_id_write(ifw[1]),
    .id_ex_bubble(bub[1]), .flush_if_id(fif[1]), .flush_id_ex(fid[1]),
    .flush_ex_mem(fex[1]), .pc_src(psrc[1]), .stall_count(sc_b), .flush_count(fc_b)
  );

  // Reference model: outstanding bubbles per instance plus event tallies.
  int n_cmp  = 0;
  int n_fail = 0;
  int lat  [2] = '{1, 3};
  int cmax [2] = '{65535, 15};
  int pend [2] = '{0, 0};
  int scnt [2] = '{0, 0};
  int fcnt [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t idle_in();
    in_t v;
    v = '{rst: 1'b0, if_rs: 5'd0, if_rt: 5'd0, ex_rs: 5'd0, ex_rt: 5'd0, memrd: 1'b0,
          ld_dest: 5'd0, exw: 1'b0, exd: 5'd0, mww: 1'b0, mwd: 5'd0, br: 1'b0, zero: 1'b0};
    return v;
  endfunction

  function automatic logic is_hz(input in_t v);
    return v.memrd && v.ld_dest != 0 && (v.ld_dest == v.if_rs || v.ld_dest == v.if_rt);
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input in_t v);
    if (v.exw && v.exd != 0 && v.exd == src) return 2'b01;
    if (v.mww && v.mwd != 0 && v.mwd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic out_t ref_out(input in_t v, input int p);
    out_t o;
    o = '{fa: ref_fwd(v.ex_rs, v), fb: ref_fwd(v.ex_rt, v), pcw: 1'b1, ifw: 1'b1,
          bub: 1'b0, fif: 1'b0, fid: 1'b0, fex: 1'b0, psrc: 1'b0};
    if (v.rst)
      o = '{fa: 2'b00, fb: 2'b00, pcw: 1'b0, ifw: 1'b0, bub: 1'b1,
            fif: 1'b1, fid: 1'b1, fex: 1'b1, psrc: 1'b0};
    else if (v.br && v.zero) begin
      o.psrc = 1'b1; o.fif = 1'b1; o.fid = 1'b1; o.fex = 1'b1;
    end else if (p > 0 || is_hz(v)) begin
      o.pcw = 1'b0; o.ifw = 1'b0; o.bub = 1'b1;
    end
    return o;
  endfunction

  function automatic int sat_inc(input int c, input int m);
    return (c >= m) ? m : c + 1;
  endfunction

  task automatic drive(input in_t v);
    reset = v.rst;
    if_id_rs = v.if_rs; if_id_rt = v.if_rt; id_ex_rs = v.ex_rs; id_ex_rt = v.ex_rt;
    id_ex_MemRead = v.memrd; id_ex_reg_dest = v.ld_dest;
    ex_mem_RegWrite = v.exw; ex_mem_reg_dest = v.exd;
    mem_wb_RegWrite = v.mww; mem_wb_reg_dest = v.mwd;
    ex_mem_Branch = v.br; ex_mem_zero = v.zero;
  endtask

  // One clock: drive on the falling edge, compare mid-cycle, advance model at the rising edge.
  task automatic cycle(input in_t v, input string tag);
    out_t e;
    @(negedge clock);
    drive(v);
    #1;
    for (int k = 0; k < 2; k++) begin
      e = ref_out(v, pend[k]);
      check($sformatf("%s/u%0d/ForwardA", tag, k), 32'(fa[k]), 32'(e.fa));
      check($sformatf("%s/u%0d/ForwardB", tag, k), 32'(fb[k]), 32'(e.fb));
      check($sformatf("%s/u%0d/pc_write", tag, k), 32'(pcw[k]), 32'(e.pcw));
      check($sformatf("%s/u%0d/if_id_write", tag, k), 32'(ifw[k]), 32'(e.ifw));
      check($sformatf("%s/u%0d/id_ex_bubble", tag, k), 32'(bub[k]), 32'(e.bub));
      check($sformatf("%s/u%0d/flush_if_id", tag, k), 32'(fif[k]), 32'(e.fif));
      check($sformatf("%s/u%0d/flush_id_ex", tag, k), 32'(fid[k]), 32'(e.fid));
      check($sformatf("%s/u%0d/flush_ex_mem", tag, k), 32'(fex[k]), 32'(e.fex));
      check($sformatf("%s/u%0d/pc_src", tag, k), 32'(psrc[k]), 32'(e.psrc));
      check($sformatf("%s/u%0d/stall_count", tag, k),
            (k == 0) ? 32'(sc_a) : 32'(sc_b), 32'(scnt[k]));
      check($sformatf("%s/u%0d/flush_count", tag, k),
            (k == 0) ? 32'(fc_a) : 32'(fc_b), 32'(fcnt[k]));
    end
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (v.rst) begin
        pend[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else if (v.br && v.zero) begin
        pend[k] = 0; fcnt[k] = sat_inc(fcnt[k], cmax[k]);
      end else if (pend[k] > 0 || is_hz(v)) begin
        scnt[k] = sat_inc(scnt[k], cmax[k]);
        pend[k] = (pend[k] > 0) ? pend[k] - 1 : lat[k] - 1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fwd_vec_t vecs [6];
    in_t v, hzv, rstv, btv;

    v = idle_in();
    rstv = v; rstv.rst = 1'b1;
    hzv = v; hzv.memrd = 1'b1; hzv.ld_dest = 5'd3; hzv.if_rt = 5'd3;
    btv = v; btv.br = 1'b1; btv.zero = 1'b1;

    vecs[0].in = v; vecs[0].in.exw = 1; vecs[0].in.exd = 5; vecs[0].in.mww = 1;
    vecs[0].in.mwd = 5; vecs[0].in.ex_rs = 5; vecs[0].in.ex_rt = 0;
    vecs[0].fa = 2'b01; vecs[0].fb = 2'b00;
    vecs[1].in = v; vecs[1].in.exw = 1; vecs[1].in.mww = 1;
    vecs[1].fa = 2'b00; vecs[1].fb = 2'b00;
    vecs[2].in = v; vecs[2].in.exd = 5; vecs[2].in.mww = 1; vecs[2].in.mwd = 5;
    vecs[2].in.ex_rs = 5; vecs[2].in.ex_rt = 5;
    vecs[2].fa = 2'b10; vecs[2].fb = 2'b10;
    vecs[3].in = v; vecs[3].in.exw = 1; vecs[3].in.exd = 7; vecs[3].in.mww = 1;
    vecs[3].in.mwd = 9; vecs[3].in.ex_rs = 9; vecs[3].in.ex_rt = 7;
    vecs[3].fa = 2'b10; vecs[3].fb = 2'b01;
    vecs[4].in = v; vecs[4].in.exw = 1; vecs[4].in.exd = 31; vecs[4].in.mwd = 31;
    vecs[4].in.ex_rs = 31; vecs[4].in.ex_rt = 31;
    vecs[4].fa = 2'b01; vecs[4].fb = 2'b01;
    vecs[5].in = v; vecs[5].in.exd = 4; vecs[5].in.mwd = 4;
    vecs[5].in.ex_rs = 4; vecs[5].in.ex_rt = 4;
    vecs[5].fa = 2'b00; vecs[5].fb = 2'b00;

    drive(rstv);
    @(posedge clock);
    cycle(rstv, "reset");
    cycle(rstv, "reset2");

    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].in, $sformatf("fwd%0d", i));
      @(negedge clock);
      drive(vecs[i].in);
      #1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("fwdtab%0d/u%0d/ForwardA", i, k), 32'(fa[k]), 32'(vecs[i].fa));
        check($sformatf("fwdtab%0d/u%0d/ForwardB", i, k), 32'(fb[k]), 32'(vecs[i].fb));
      end
    end

    // Single load-use hazard, then idle cycles.
    cycle(hzv, "lu_hz");
    for (int i = 0; i < 4; i++) cycle(v, $sformatf("lu_idle%0d", i));
    #1;
    check("lu/stall_count_l1", 32'(sc_a), 32'd1);
    check("lu/stall_count_l3", 32'(sc_b), 32'd3);

    // Hazard and taken branch together: flush only.
    v = hzv; v.br = 1'b1; v.zero = 1'b1;
    cycle(v, "hz_bt");
    #1;
    check("hz_bt/flush_count_l1", 32'(fc_a), 32'd1);
    check("hz_bt/stall_count_l1", 32'(sc_a), 32'd1);
    check("hz_bt/stall_count_l3", 32'(sc_b), 32'd3);
    v = idle_in();
    cycle(v, "hz_bt_after");

    // Branch during the second cycle of a 3-cycle stall.
    cycle(hzv, "abort_hz");
    cycle(btv, "abort_bt");
    #1;
    check("abort/pc_write_l3", 32'(pcw[1]), 32'd1);
    check("abort/stall_count_l3", 32'(sc_b), 32'd4);
    cycle(v, "abort_after");

    // Reset during a stall.
    cycle(hzv, "rst_hz");
    cycle(rstv, "rst_mid1");
    cycle(rstv, "rst_mid2");
    cycle(v, "rst_after");
    #1;
    check("rst_after/pc_write_l3", 32'(pcw[1]), 32'd1);
    check("rst_after/stall_count_l3", 32'(sc_b), 32'd0);
    check("rst_after/flush_count_l1", 32'(fc_a), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v.rst     = ($urandom_range(0, 49) == 0);
      v.if_rs   = 5'($urandom_range(0, 3));
      v.if_rt   = 5'($urandom_range(0, 3));
      v.ex_rs   = 5'($urandom_range(0, 3));
      v.ex_rt   = 5'($urandom_range(0, 3));
      v.memrd   = 1'($urandom_range(0, 1));
      v.ld_dest = 5'($urandom_range(0, 3));
      v.exw     = 1'($urandom_range(0, 1));
      v.exd     = 5'($urandom_range(0, 3));
      v.mww     = 1'($urandom_range(0, 1));
      v.mwd     = 5'($urandom_range(0, 3));
      v.br      = ($urandom_range(0, 5) == 0);
      v.zero    = 1'($urandom_range(0, 1));
      cycle(v, $sformatf("rnd%0d", i));
    end

    // Counter saturation on the 4-bit instance.
    cycle(rstv, "sat_rst");
    for (int i = 0; i < 20; i++) cycle(hzv, $sformatf("sat%0d", i));
    #1;
    check("sat/stall_count_l3", 32'(sc_b), 32'd15);
    check("sat/stall_count_l1", 32'(sc_a), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_ex_hazard_ctrl
